// File: rtl/dma_req_sched_if.sv
// Request, DMA-controller and completion signals of the round-robin DMA request scheduler.
// The slave modport is the scheduler's view; master is the surrounding system's view.
interface dma_req_sched_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned IDW        = 2
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_direction;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_from_addr;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_to_addr;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_length;

  logic                          dma_direction;
  logic [ADDR_WIDTH-1:0]         dma_from_addr;
  logic [ADDR_WIDTH-1:0]         dma_to_addr;
  logic [ADDR_WIDTH-1:0]         dma_length;
  logic                          dma_cpu_en;
  logic                          dma_busy;

  logic                          cmp_valid;
  logic [IDW-1:0]                cmp_id;
  logic                          cmp_error;

  modport slave (
    input  req_valid, req_direction, req_from_addr, req_to_addr, req_length, dma_busy,
    output req_ready, dma_direction, dma_from_addr, dma_to_addr, dma_length, dma_cpu_en,
    output cmp_valid, cmp_id, cmp_error
  );

  modport master (
    output req_valid, req_direction, req_from_addr, req_to_addr, req_length, dma_busy,
    input  req_ready, dma_direction, dma_from_addr, dma_to_addr, dma_length, dma_cpu_en,
    input  cmp_valid, cmp_id, cmp_error
  );
endinterface

// File: rtl/dma_req_sched.sv
// Round-robin scheduler sharing one DMA controller between NUM_REQ requesters.
// One descriptor in flight; completion or start-timeout is reported with the requester id.
module dma_req_sched #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned ADDR_WIDTH    = 64,
  parameter int unsigned START_TIMEOUT = 16
) (
  input logic            aclk,
  input logic            areset,
  dma_req_sched_if.slave bus
);
  localparam int unsigned IDW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StIssue, StWaitStart, StWaitDone, StResp} state_e;

  state_e                state_q;
  logic [IDW-1:0]        rr_ptr_q, id_q, cmp_id_q;
  logic [CntW-1:0]       cnt_q;
  logic                  dma_direction_q, dma_cpu_en_q, cmp_valid_q, cmp_error_q;
  logic [ADDR_WIDTH-1:0] dma_from_q, dma_to_q, dma_len_q;

  logic [IDW-1:0]        grant_id, hi_id, lo_id;
  logic                  hi_found, lo_found, accept;
  logic                  sel_dir;
  logic [ADDR_WIDTH-1:0] sel_from, sel_to, sel_len;
  logic [NUM_REQ-1:0]    ready;

  // Lowest valid index at or above rr_ptr wins; otherwise wrap to the lowest valid index.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        lo_found = 1'b1;
        lo_id    = IDW'(i);
        if (IDW'(i) >= rr_ptr_q) begin
          hi_found = 1'b1;
          hi_id    = IDW'(i);
        end
      end
    end
    grant_id = hi_found ? hi_id : lo_id;
  end

  always_comb begin
    sel_dir  = 1'b0;
    sel_from = '0;
    sel_to   = '0;
    sel_len  = '0;
    ready    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == IDW'(i)) begin
        sel_dir  = bus.req_direction[i];
        sel_from = bus.req_from_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_to   = bus.req_to_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_len  = bus.req_length[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
      ready[i] = (state_q == StIdle) && lo_found && !bus.dma_busy && !areset &&
                 (grant_id == IDW'(i));
    end
  end

  assign accept = |ready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q         <= StIdle;
      rr_ptr_q        <= '0;
      id_q            <= '0;
      cnt_q           <= '0;
      dma_direction_q <= 1'b0;
      dma_from_q      <= '0;
      dma_to_q        <= '0;
      dma_len_q       <= '0;
      dma_cpu_en_q    <= 1'b0;
      cmp_valid_q     <= 1'b0;
      cmp_id_q        <= '0;
      cmp_error_q     <= 1'b0;
    end else begin
      dma_cpu_en_q <= 1'b0;
      cmp_valid_q  <= 1'b0;
      cmp_id_q     <= '0;
      cmp_error_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            dma_direction_q <= sel_dir;
            dma_from_q      <= sel_from;
            dma_to_q        <= sel_to;
            dma_len_q       <= sel_len;
            id_q            <= grant_id;
            rr_ptr_q        <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
            // Zero-length descriptors complete without touching the controller.
            if (sel_len == '0) begin
              state_q     <= StResp;
              cmp_valid_q <= 1'b1;
              cmp_id_q    <= grant_id;
            end else begin
              state_q      <= StIssue;
              dma_cpu_en_q <= 1'b1;
            end
          end
        end
        StIssue: begin
          cnt_q   <= '0;
          state_q <= StWaitStart;
        end
        StWaitStart: begin
          if (bus.dma_busy) begin
            state_q <= StWaitDone;
          end else if (cnt_q == CntW'(START_TIMEOUT - 1)) begin
            state_q     <= StResp;
            cmp_valid_q <= 1'b1;
            cmp_id_q    <= id_q;
            cmp_error_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StWaitDone: begin
          if (!bus.dma_busy) begin
            state_q     <= StResp;
            cmp_valid_q <= 1'b1;
            cmp_id_q    <= id_q;
          end
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready     = ready;
  assign bus.dma_direction = dma_direction_q;
  assign bus.dma_from_addr = dma_from_q;
  assign bus.dma_to_addr   = dma_to_q;
  assign bus.dma_length    = dma_len_q;
  assign bus.dma_cpu_en    = dma_cpu_en_q;
  assign bus.cmp_valid     = cmp_valid_q;
  assign bus.cmp_id        = cmp_id_q;
  assign bus.cmp_error     = cmp_error_q;
endmodule

// File: tb/tb_dma_req_sched.sv
// Directed bench for dma_req_sched: table of single-requester transactions plus
// hand sequences for reset, contention, busy-in-idle and reset mid-transfer.
module tb_dma_req_sched;
  localparam int NR = 4;
  localparam int AW = 64;

  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  dma_req_sched_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .IDW(2)) bus ();

  dma_req_sched #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .START_TIMEOUT(16)) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          id;
    logic        dir;
    logic [63:0] from;
    logic [63:0] to;
    logic [63:0] len;
    int          busy_len;   // 0 with nonzero len: controller never starts
    int          exp_lat;    // cycles from accept to cmp_valid
    logic        exp_err;
    logic [3:0]  exp_ready;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_req(input int id, input logic dir, input logic [63:0] from,
                         input logic [63:0] to, input logic [63:0] len);
    bus.req_direction[id]          = dir;
    bus.req_from_addr[id*AW +: AW] = from;
    bus.req_to_addr[id*AW +: AW]   = to;
    bus.req_length[id*AW +: AW]    = len;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 64'(bus.req_ready), 64'd0);
    check({tag, "_cpu_en"}, 64'(bus.dma_cpu_en), 64'd0);
    check({tag, "_dir"}, 64'(bus.dma_direction), 64'd0);
    check({tag, "_from"}, bus.dma_from_addr, 64'd0);
    check({tag, "_to"}, bus.dma_to_addr, 64'd0);
    check({tag, "_len"}, bus.dma_length, 64'd0);
    check({tag, "_cmp_valid"}, 64'(bus.cmp_valid), 64'd0);
    check({tag, "_cmp_id"}, 64'(bus.cmp_id), 64'd0);
    check({tag, "_cmp_error"}, 64'(bus.cmp_error), 64'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int          en_cnt, en_cyc, cmp_cyc;
    logic        f_dir, c_err;
    logic [63:0] f_from, f_to, f_len;
    logic [1:0]  c_id;
    en_cnt = 0; en_cyc = -1; cmp_cyc = -1;
    f_dir = 1'b0; f_from = '0; f_to = '0; f_len = '0; c_id = '0; c_err = 1'b0;
    tick();
    bus.dma_busy  = 1'b0;
    bus.req_valid = '0;
    set_req(v.id, v.dir, v.from, v.to, v.len);
    bus.req_valid[v.id] = 1'b1;
    #1;
    check("vec_ready", 64'(bus.req_ready), 64'(v.exp_ready));
    for (int c = 1; c <= 40 && cmp_cyc < 0; c++) begin
      tick();
      bus.req_valid = '0;
      bus.dma_busy  = (c >= 2) && (c < 2 + v.busy_len);
      if (bus.dma_cpu_en) begin
        en_cnt++;
        en_cyc = c;
        f_dir  = bus.dma_direction;
        f_from = bus.dma_from_addr;
        f_to   = bus.dma_to_addr;
        f_len  = bus.dma_length;
      end
      if (bus.cmp_valid) begin
        cmp_cyc = c;
        c_id    = bus.cmp_id;
        c_err   = bus.cmp_error;
      end
    end
    check("vec_issue_count", 64'(en_cnt), (v.len != 0) ? 64'd1 : 64'd0);
    if (v.len != 0) begin
      check("vec_issue_cycle", 64'(en_cyc), 64'd1);
      check("vec_dir", 64'(f_dir), 64'(v.dir));
      check("vec_from", f_from, v.from);
      check("vec_to", f_to, v.to);
      check("vec_len", f_len, v.len);
    end
    check("vec_cmp_cycle", 64'(cmp_cyc), 64'(v.exp_lat));
    check("vec_cmp_id", 64'(c_id), 64'(v.id));
    check("vec_cmp_error", 64'(c_err), 64'(v.exp_err));
    tick();
    check("vec_cmp_one_cycle", 64'(bus.cmp_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int grants[5];
    int cids[5];
    int exp_order[5];
    int ng, nc, left, gi, seen_cmp, seen_en;

    vecs[0] = '{2, 1'b1, 64'h1000, 64'h2000, 64'h40, 5, 8, 1'b0, 4'b0100};
    vecs[1] = '{1, 1'b0, 64'h3000, 64'h4000, 64'h0, 0, 1, 1'b0, 4'b0010};
    vecs[2] = '{3, 1'b0, 64'hA000_0000_0000_0000, 64'h55, 64'h10, 1, 4, 1'b0, 4'b1000};
    vecs[3] = '{0, 1'b1, 64'h10, 64'h20, 64'h8, 0, 18, 1'b1, 4'b0001};
    vecs[4] = '{2, 1'b0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 3, 6, 1'b0,
                4'b0100};
    exp_order = '{0, 1, 2, 3, 0};

    // Reset with every requester asking: nothing may be granted or driven.
    areset            = 1'b1;
    bus.dma_busy      = 1'b0;
    bus.req_valid     = '1;
    bus.req_direction = '1;
    bus.req_from_addr = '1;
    bus.req_to_addr   = '1;
    bus.req_length    = '1;
    #12;
    check_all_zero("reset");
    tick();
    areset        = 1'b0;
    bus.req_valid = '0;

    // Contention: all requesters valid, 3-cycle transfers.
    for (int i = 0; i < NR; i++) set_req(i, i[0], 64'(i * 'h100), 64'(i * 'h200), 64'h1);
    ng = 0; nc = 0; left = 0;
    tick();
    bus.req_valid = '1;
    for (int c = 0; c < 200 && nc < 5; c++) begin
      if (bus.cmp_valid) begin
        if (nc < 5) cids[nc] = int'(bus.cmp_id);
        nc++;
      end
      bus.dma_busy = (left > 0);
      if (left > 0) left--;
      if (bus.dma_cpu_en) left = 3;
      if (ng >= 5) bus.req_valid = '0;
      #1;
      if (bus.req_ready != '0) begin
        check("rr_onehot", 64'($countones(bus.req_ready)), 64'd1);
        gi = 0;
        for (int i = 0; i < NR; i++) if (bus.req_ready[i]) gi = i;
        if (ng < 5) grants[ng] = gi;
        ng++;
      end
      tick();
    end
    bus.dma_busy  = 1'b0;
    bus.req_valid = '0;
    check("rr_grant_count", 64'(ng), 64'd5);
    check("rr_cmp_count", 64'(nc), 64'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < ng) check("rr_grant_order", 64'(grants[k]), 64'(exp_order[k]));
      if (k < nc) check("rr_cmp_order", 64'(cids[k]), 64'(exp_order[k]));
    end

    // Busy in idle blocks acceptance until the first idle cycle.
    set_req(0, 1'b0, 64'h7000, 64'h8000, 64'h20);
    bus.dma_busy  = 1'b1;
    bus.req_valid = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("busy_idle_blocked", 64'(bus.req_ready), 64'd0);
      tick();
    end
    bus.dma_busy = 1'b0;
    #1;
    check("busy_idle_accept", 64'(bus.req_ready), 64'b0001);
    tick();
    bus.req_valid = '0;
    check("busy_idle_issue", 64'(bus.dma_cpu_en), 64'd1);
    seen_cmp = 0;
    for (int c = 0; c < 40 && seen_cmp == 0; c++) begin
      tick();
      if (bus.cmp_valid) begin
        seen_cmp = 1;
        check("busy_idle_timeout_err", 64'(bus.cmp_error), 64'd1);
        check("busy_idle_id", 64'(bus.cmp_id), 64'd0);
      end
    end
    check("busy_idle_cmp_seen", 64'(seen_cmp), 64'd1);

    for (int k = 0; k < 5; k++) run_vec(vecs[k]);

    // Reset while the controller is busy abandons the descriptor.
    tick();
    bus.req_valid = 4'b0010;
    set_req(1, 1'b1, 64'h5000, 64'h6000, 64'h40);
    #1;
    check("rst_mid_ready", 64'(bus.req_ready), 64'b0010);
    tick();
    bus.req_valid = '0;
    tick();
    bus.dma_busy = 1'b1;
    tick();
    tick();
    check("rst_mid_fields_loaded", bus.dma_from_addr, 64'h5000);
    bus.req_valid = '1;
    #2;
    areset = 1'b1;
    #1;
    check_all_zero("rst_mid");
    bus.dma_busy = 1'b0;
    tick();
    tick();
    areset        = 1'b0;
    bus.req_valid = '0;
    seen_cmp = 0; seen_en = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (bus.cmp_valid) seen_cmp++;
      if (bus.dma_cpu_en) seen_en++;
    end
    check("rst_mid_no_cmp", 64'(seen_cmp), 64'd0);
    check("rst_mid_no_reissue", 64'(seen_en), 64'd0);
    bus.req_valid = '1;
    #1;
    check("rst_mid_rr_ptr", 64'(bus.req_ready), 64'b0001);
    bus.req_valid = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dma_req_sched.md
Name: dma_req_sched

Overview:
- Round-robin scheduler that shares one DMA controller between NUM_REQ requesters (CPU harts, debug module, peripheral engines).
- Accepts one descriptor at a time (direction, source, destination, length) over a valid/ready handshake.
- Drives the controller's command inputs and issue strobe, then tracks the controller's busy flag to completion.
- Returns a one-cycle completion (or timeout error) tagged with the requester id.

Parameters:
- NUM_REQ, 4: number of requesters, >=1.
- ADDR_WIDTH, 64: address/length width.
- START_TIMEOUT, 16: cycles allowed for dma_busy to rise after issue, >=1.
- IDW (localparam): $clog2(NUM_REQ), or 1 if NUM_REQ==1.

Ports:
- aclk  in  1  clock, all logic on rising edge.
- areset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  descriptor valid, one bit per requester.
- req_ready  out  NUM_REQ  descriptor accepted; at most one bit set.
- req_direction  in  NUM_REQ  per-requester direction (0: a->b, 1: b->a).
- req_from_addr  in  NUM_REQ*ADDR_WIDTH  requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_to_addr  in  NUM_REQ*ADDR_WIDTH  same packing.
- req_length  in  NUM_REQ*ADDR_WIDTH  same packing.
- dma_direction  out  1  to controller.
- dma_from_addr  out  ADDR_WIDTH  to controller.
- dma_to_addr  out  ADDR_WIDTH  to controller.
- dma_length  out  ADDR_WIDTH  to controller.
- dma_cpu_en  out  1  one-cycle issue strobe.
- dma_busy  in  1  controller busy.
- cmp_valid  out  1  one-cycle completion pulse.
- cmp_id  out  IDW  requester index of the completed descriptor.
- cmp_error  out  1  qualifies cmp_valid: 1 = start timeout.

Behaviour:
- Reset (areset=1, asynchronous):
  - state=IDLE, rr_ptr=0, counter=0.
  - All outputs 0: req_ready, dma_* fields, dma_cpu_en, cmp_*.
  - Reset mid-transfer abandons the descriptor: no completion is reported and dma_cpu_en is never re-asserted for it.
- States: IDLE, ISSUE, WAIT_START, WAIT_DONE, RESP.
- IDLE:
  - Grant g = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready is combinational: one-hot at g only when state==IDLE, any req_valid is set, and dma_busy==0. Otherwise all zero.
  - dma_busy==1 in IDLE blocks acceptance.
  - On accept (valid&ready): latch g's descriptor into dma_*, latch id=g, set rr_ptr=(g+1) mod NUM_REQ.
  - If accepted length==0 -> RESP with error=0; no issue is made.
  - Otherwise -> ISSUE.
- ISSUE: dma_cpu_en=1 for exactly this cycle; counter=0; -> WAIT_START.
- WAIT_START:
  - If dma_busy=1 -> WAIT_DONE.
  - Otherwise counter++. When counter reaches START_TIMEOUT with busy still 0 -> RESP with error=1.
- WAIT_DONE: stay while dma_busy=1; on dma_busy=0 -> RESP with error=0.
- RESP:
  - cmp_valid=1 for one cycle, with cmp_id=latched id and cmp_error as set on entry.
  - -> IDLE.
  - No backpressure on the completion.
- Outputs and timing:
  - dma_direction/from/to/length are registered, stable from ISSUE until the next accept.
  - All outputs except req_ready are registered.
  - Timing from accept at cycle T: dma_cpu_en at T+1; earliest cmp_valid at T+4 (busy high T+2, low T+3). Zero-length: cmp_valid at T+1.
  - Next accept no earlier than the cycle after RESP.
- Single outstanding descriptor; no queuing; req_valid from non-granted requesters is ignored until granted.
- Simultaneous requests: only one grant per accept, strictly round-robin. No requester is starved if all hold req_valid.
- req_valid dropped before grant: not tracked, no side effects.

Test Plan:
- Single request: req 2 valid, dir=1, from=0x1000, to=0x2000, len=0x40; controller asserts busy for 5 cycles from T+2.
  - Expect req_ready[2] at T.
  - Expect dma_cpu_en only at T+1, with dma_* = descriptor values.
  - Expect cmp_valid with id=2, error=0 at the cycle after busy falls.
- Contention: all 4 valid continuously, 3-cycle transfers.
  - Expect grant order 0,1,2,3,0.
  - Expect exactly one req_ready bit per accept.
- Zero length: req 1, len=0 at T -> cmp_valid id=1, error=0 at T+1; dma_cpu_en never asserted.
- Timeout: START_TIMEOUT=16, busy held 0 after issue -> cmp_valid with error=1, 16 cycles after the WAIT_START entry; then IDLE accepts a new request.
- Busy in IDLE: dma_busy=1 with req 0 valid -> req_ready=0 throughout; accept occurs on the first cycle busy=0.
- Reset mid-transfer: assert areset during WAIT_DONE.
  - All outputs 0 immediately.
  - No cmp_valid afterwards.
  - rr_ptr=0, so the next grant goes to req 0 when all are valid.
